// File: rtl/pipeline_controller.sv
// Pipeline hazard/boot controller: load-use stall, jump flush, boot hold.
// Optional perf counters enabled by defining PIPELINE_CONTROLLER_PERF_CNT_EN.
module pipeline_controller #(
  parameter int LOAD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        boot_done,
  input  logic [15:0] dec_rs1,
  input  logic [15:0] dec_rs2,
  input  logic [15:0] ex_rd,
  input  logic        ex_memread,
  input  logic        ex_regwrite,
  input  logic        jump,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        pipe_run,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_RUN   = 2'b01,
    S_STALL = 2'b10,
    S_FLUSH = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       hazard;

  assign hazard = ex_memread & ex_regwrite & (ex_rd != 16'h0000) &
                  ((ex_rd == dec_rs1) | (ex_rd == dec_rs2));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_BOOT;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_run   = 1'b1;
    case (state_q)
      S_BOOT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        pipe_run   = 1'b0;
        if (boot_done) state_d = S_RUN;
      end
      S_RUN: begin
        // Hazard beats jump: decode operands are stale while a load is in flight.
        if (hazard) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = S_STALL;
            cnt_d   = 2'(LOAD_LAT - 1);
          end
        end else if (jump) begin
          ifid_flush = 1'b1;
          state_d    = S_FLUSH;
        end
      end
      S_STALL: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        if (cnt_q == 2'd1) begin
          state_d = S_RUN;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_FLUSH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_d    = S_RUN;
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign state = state_q;

`ifdef PIPELINE_CONTROLLER_PERF_CNT_EN
  logic        stall_cycle, jump_accept;
  logic [15:0] stall_cnt_q, flush_cnt_q;

  assign stall_cycle = (state_q == S_STALL) | ((state_q == S_RUN) & hazard);
  assign jump_accept = (state_q == S_RUN) & ~hazard & jump;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      if (stall_cycle && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'h0001;
      if (jump_accept && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'h0001;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench: two controllers (LOAD_LAT=1 and LOAD_LAT=3) driven by shared inputs.
module tb_pipeline_controller;

`ifdef PIPELINE_CONTROLLER_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_write, ifid_write, ifid_flush, idex_flush}
  localparam logic [3:0] C_BOOT  = 4'b0011;
  localparam logic [3:0] C_RUN   = 4'b1100;
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_JUMP  = 4'b1110;
  localparam logic [3:0] C_FLUSH = 4'b1111;

  logic        clk = 1'b0;
  logic        reset, boot_done, ex_memread, ex_regwrite, jump;
  logic [15:0] dec_rs1, dec_rs2, ex_rd;

  logic        pc_write1, ifid_write1, ifid_flush1, idex_flush1, pipe_run1;
  logic [1:0]  state1;
  logic [15:0] stall_cnt1, flush_cnt1;
  logic        pc_write3, ifid_write3, ifid_flush3, idex_flush3, pipe_run3;
  logic [1:0]  state3;
  logic [15:0] stall_cnt3, flush_cnt3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_controller #(.LOAD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .boot_done(boot_done),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .jump(jump),
    .pc_write(pc_write1), .ifid_write(ifid_write1), .ifid_flush(ifid_flush1),
    .idex_flush(idex_flush1), .pipe_run(pipe_run1), .state(state1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  pipeline_controller #(.LOAD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .boot_done(boot_done),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .jump(jump),
    .pc_write(pc_write3), .ifid_write(ifid_write3), .ifid_flush(ifid_flush3),
    .idex_flush(idex_flush3), .pipe_run(pipe_run3), .state(state3),
    .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
  );

  wire [3:0] ctl1 = {pc_write1, ifid_write1, ifid_flush1, idex_flush1};
  wire [3:0] ctl3 = {pc_write3, ifid_write3, ifid_flush3, idex_flush3};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    ex_memread = 1'b0; ex_regwrite = 1'b0; jump = 1'b0;
    ex_rd = 16'h0000; dec_rs1 = 16'h0000; dec_rs2 = 16'h0000;
  endtask

  task automatic load_hazard();
    ex_memread = 1'b1; ex_regwrite = 1'b1;
    ex_rd = 16'h0003; dec_rs1 = 16'h0000; dec_rs2 = 16'h0003;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; boot_done = 1'b0;
    idle_inputs();
    tick(); tick();
    settle();
    check("rst_state1", 16'(state1), 16'h0);
    check("rst_state3", 16'(state3), 16'h0);
    check("rst_ctl1", 16'(ctl1), 16'(C_BOOT));
    check("rst_piperun1", 16'(pipe_run1), 16'h0);
    check("rst_stall1", stall_cnt1, 16'h0);
    check("rst_flush3", flush_cnt3, 16'h0);

    // Held in BOOT while boot_done is low, whatever else is driven.
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load_hazard();
      jump = 1'b1;
      settle();
      check("boot_state1", 16'(state1), 16'h0);
      check("boot_ctl1", 16'(ctl1), 16'(C_BOOT));
      check("boot_ctl3", 16'(ctl3), 16'(C_BOOT));
      tick();
    end
    idle_inputs();
    boot_done = 1'b1;
    tick();
    boot_done = 1'b0;
    settle();
    check("run_state1", 16'(state1), 16'h1);
    check("run_state3", 16'(state3), 16'h1);
    check("run_ctl1", 16'(ctl1), 16'(C_RUN));
    check("run_piperun3", 16'(pipe_run3), 16'h1);

    // Non-hazards: ex_rd zero, not a load, no register write.
    load_hazard(); ex_rd = 16'h0000; dec_rs2 = 16'h0000;
    settle();
    check("rd0_ctl1", 16'(ctl1), 16'(C_RUN));
    load_hazard(); ex_memread = 1'b0;
    settle();
    check("noload_ctl3", 16'(ctl3), 16'(C_RUN));
    load_hazard(); ex_regwrite = 1'b0;
    settle();
    check("nowr_ctl3", 16'(ctl3), 16'(C_RUN));
    load_hazard(); dec_rs2 = 16'h0103;
    settle();
    check("wide_cmp_ctl1", 16'(ctl1), 16'(C_RUN));
    tick();
    check("nohaz_state3", 16'(state3), 16'h1);

    // Load-use hazard on rs2.
    load_hazard();
    settle();
    check("haz_ctl1", 16'(ctl1), 16'(C_STALL));
    check("haz_ctl3", 16'(ctl3), 16'(C_STALL));
    tick();
    // dut1 is back in RUN and takes the jump; dut3 is stalling and ignores it.
    idle_inputs();
    jump = 1'b1;
    settle();
    check("l1_state_after_haz", 16'(state1), 16'h1);
    check("l1_stall_cnt", stall_cnt1, PERF ? 16'd1 : 16'd0);
    check("l1_jump_ctl", 16'(ctl1), 16'(C_JUMP));
    check("l3_state_stall_a", 16'(state3), 16'h2);
    check("l3_stall_ctl_a", 16'(ctl3), 16'(C_STALL));
    check("l3_stall_cnt_a", stall_cnt3, PERF ? 16'd1 : 16'd0);
    tick();
    settle();
    check("l1_state_flush", 16'(state1), 16'h3);
    check("l1_flush_ctl", 16'(ctl1), 16'(C_FLUSH));
    check("l1_flush_cnt", flush_cnt1, PERF ? 16'd1 : 16'd0);
    check("l3_state_stall_b", 16'(state3), 16'h2);
    check("l3_stall_ctl_b", 16'(ctl3), 16'(C_STALL));
    tick();
    jump = 1'b0;
    settle();
    check("l1_state_back", 16'(state1), 16'h1);
    check("l1_ctl_back", 16'(ctl1), 16'(C_RUN));
    check("l1_flush_cnt_hold", flush_cnt1, PERF ? 16'd1 : 16'd0);
    check("l3_state_back", 16'(state3), 16'h1);
    check("l3_stall_cnt_3", stall_cnt3, PERF ? 16'd3 : 16'd0);
    check("l3_flush_cnt_0", flush_cnt3, 16'h0);

    // Hazard on rs1 together with a jump: stall only.
    load_hazard(); dec_rs1 = 16'h0003; dec_rs2 = 16'h0000; jump = 1'b1;
    settle();
    check("hj_ctl1", 16'(ctl1), 16'(C_STALL));
    check("hj_ctl3", 16'(ctl3), 16'(C_STALL));
    tick();
    idle_inputs();
    settle();
    check("hj_state1", 16'(state1), 16'h1);
    check("hj_flush_cnt1", flush_cnt1, PERF ? 16'd1 : 16'd0);
    check("hj_stall_cnt1", stall_cnt1, PERF ? 16'd2 : 16'd0);
    check("hj_state3_a", 16'(state3), 16'h2);
    tick();
    settle();
    check("hj_state3_b", 16'(state3), 16'h2);
    tick();
    settle();
    check("hj_state3_c", 16'(state3), 16'h1);
    check("hj_stall_cnt3", stall_cnt3, PERF ? 16'd6 : 16'd0);
    check("hj_flush_cnt3", flush_cnt3, 16'h0);

    // Continuous hazard well past 16 bits of stall cycles: counters saturate.
    load_hazard();
    for (int i = 0; i < 65540; i++) tick();
    settle();
    check("sat_stall_cnt1", stall_cnt1, PERF ? 16'hFFFF : 16'h0);
    check("sat_stall_cnt3", stall_cnt3, PERF ? 16'hFFFF : 16'h0);
    tick(); tick();
    check("sat_hold_cnt1", stall_cnt1, PERF ? 16'hFFFF : 16'h0);

    // Reset mid-STALL (dut3 is stalling here) abandons everything.
    reset = 1'b0;
    tick();
    settle();
    check("mid_rst_state3", 16'(state3), 16'h0);
    check("mid_rst_ctl3", 16'(ctl3), 16'(C_BOOT));
    check("mid_rst_stall3", stall_cnt3, 16'h0);
    check("mid_rst_stall1", stall_cnt1, 16'h0);
    check("mid_rst_flush1", flush_cnt1, 16'h0);
    reset = 1'b1; boot_done = 1'b1; idle_inputs();
    tick();
    settle();
    check("reboot_state3", 16'(state3), 16'h1);
    check("reboot_ctl3", 16'(ctl3), 16'(C_RUN));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter LOAD_LAT, default 1, load-use stall length in cycles; legal range 1..3.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low; reset=0 sampled at a rising edge resets the block.
REQ-004 boot_done  input  1  external register-file loader has finished (loadAddr/loadData/rf_write phase complete).
REQ-005 dec_rs1  input  16  Rs1 of the instruction in decode.
REQ-006 dec_rs2  input  16  Rs2 of the instruction in decode.
REQ-007 ex_rd  input  16  Rd of the instruction in execute.
REQ-008 ex_memread  input  1  execute-stage instruction is a load.
REQ-009 ex_regwrite  input  1  execute-stage instruction writes a register.
REQ-010 jump  input  1  decode resolved a taken jump (new_pc valid).
REQ-011 pc_write  output  1  PC register update enable.
REQ-012 ifid_write  output  1  IF/ID register update enable.
REQ-013 ifid_flush  output  1  clear IF/ID to a bubble.
REQ-014 idex_flush  output  1  insert a bubble into ID/EX (zero RegWrite, MemWrite, MemRead, RegStore).
REQ-015 pipe_run  output  1  high when pipeline is out of BOOT.
REQ-016 state  output  2  FSM state for debug: BOOT=00, RUN=01, STALL=10, FLUSH=11.
REQ-017 stall_cnt  output  16  count of stall cycles.
REQ-018 flush_cnt  output  16  count of accepted jumps.

Function
REQ-019 hazard (combinational) = ex_memread & ex_regwrite & (ex_rd != 0) & ((ex_rd == dec_rs1) | (ex_rd == dec_rs2)); full 16-bit compares.
REQ-020 BOOT: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pipe_run=0; boot_done=1 at a rising edge -> RUN next cycle; all other inputs ignored.
REQ-021 RUN with hazard=1: same cycle pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0; next state STALL with down-counter=LOAD_LAT-1 if LOAD_LAT>1, else stay RUN.
REQ-022 RUN with hazard=1 and jump=1 simultaneously: hazard wins, jump ignored that cycle (decode operands not yet valid).
REQ-023 RUN with hazard=0, jump=1: same cycle pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=0; next state FLUSH.
REQ-024 RUN with hazard=0, jump=0: pc_write=1, ifid_write=1, both flushes 0.
REQ-025 STALL: outputs as REQ-021; hazard and jump ignored; counter decrements each cycle; when counter==1 -> RUN next cycle; total stall = LOAD_LAT cycles.
REQ-026 FLUSH: exactly one cycle; pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1; jump and hazard ignored; -> RUN.
REQ-027 boot_done deassertion outside BOOT has no effect.
REQ-028 pipe_run=1 in RUN, STALL, FLUSH.
REQ-029 Outputs pc_write, ifid_write, ifid_flush, idex_flush are combinational from state and inputs; state, counters registered.

Reset
REQ-030 On reset: state=BOOT, stall down-counter=0, stall_cnt=0, flush_cnt=0; outputs take BOOT values (REQ-020) the cycle after reset is sampled.
REQ-031 Reset mid-STALL or mid-FLUSH abandons the operation; no partial counter updates on the reset edge.

Configuration
REQ-032 Macro PIPELINE_CONTROLLER_PERF_CNT_EN defined: stall_cnt increments (saturating at 16'hFFFF) each cycle of REQ-021/REQ-025 stall outputs; flush_cnt increments (saturating) for each jump accepted per REQ-023.
REQ-033 Macro undefined: counter logic absent; stall_cnt and flush_cnt tied to 16'h0000.

Verification
REQ-034 reset=0 two cycles, then reset=1, boot_done=0 for 5 cycles -> state=00, pc_write=0, ifid_flush=1, idex_flush=1 throughout; boot_done=1 -> state=01 next cycle, pc_write=1.
REQ-035 LOAD_LAT=1, RUN, ex_memread=1, ex_regwrite=1, ex_rd=16'h0003, dec_rs2=16'h0003 -> one cycle pc_write=0, idex_flush=1; stall_cnt=1 (macro on); ex_rd=0 same case -> no stall.
REQ-036 LOAD_LAT=3, same hazard -> exactly 3 stall cycles, state 01->10->10->01, jump=1 during STALL ignored, flush_cnt unchanged.
REQ-037 RUN, jump=1 one cycle, hazard=0 -> ifid_flush=1 that cycle and next (state=11), idex_flush=1 only in FLUSH cycle, flush_cnt=1; jump with hazard simultaneous -> stall only, flush_cnt unchanged.
REQ-038 Force stall_cnt to 16'hFFFE via 2+ continuous hazard cycles beyond saturation -> holds 16'hFFFF; reset=0 mid-STALL -> state=00, counters 0 next cycle; macro off -> counters read 0.
